exmem_stage: RTL and testbench

- EX/MEM boundary of the 5-stage pipeline: latches execute-stage results and sequences the single data-memory access for the instruction in MEM.
- Also owns the LL/SC link register.
- Consumes the ALU result and control bundles carried out of the ID/EX latch and EX.
- Drives the dcache request, plus a stall back to IF/ID/EX while the access is outstanding.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/exmem_if.sv | 46 ++++
 rtl/link_reg.sv | 47 ++++
 rtl/exmem_stage.sv | 148 ++++++++++++++
 tb/tb_exmem_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline latches: datapath word, MEMctrl bit
// positions and the EX/MEM access sequencer states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned MEM_REN = 0;
    localparam int unsigned MEM_WEN = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } exmem_state_t;

endpackage

// File: rtl/exmem_if.sv
// EX/MEM boundary bundle: upstream latch inputs, dcache request/response,
// snoop invalidate and the latched outputs toward WB.
interface exmem_if #(
    parameter int unsigned WB_W   = 4,
    parameter int unsigned MEM_W  = 2,
    parameter int unsigned WORD_W = 32
);
    logic              ihit;
    logic              flush_EXMEM;
    logic [WORD_W-1:0] aluout_in;
    logic [WORD_W-1:0] rdat2_in;
    logic [WORD_W-1:0] npc_in;
    logic [WORD_W-1:0] instr_in;
    logic [WB_W-1:0]   WBctrl_in;
    logic [MEM_W-1:0]  MEMctrl_in;
    logic              datomic_in;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              ccinv;
    logic [WORD_W-1:0] ccsnoopaddr;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              mem_stall;
    logic [WORD_W-1:0] aluout_out;
    logic [WORD_W-1:0] npc_out;
    logic [WORD_W-1:0] instr_out;
    logic [WB_W-1:0]   WBctrl_out;
    logic [WORD_W-1:0] dload_out;

    modport slave (
        input  ihit, flush_EXMEM, aluout_in, rdat2_in, npc_in, instr_in,
               WBctrl_in, MEMctrl_in, datomic_in, dhit, dmemload, ccinv, ccsnoopaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               aluout_out, npc_out, instr_out, WBctrl_out, dload_out
    );

    modport master (
        output ihit, flush_EXMEM, aluout_in, rdat2_in, npc_in, instr_in,
               WBctrl_in, MEMctrl_in, datomic_in, dhit, dmemload, ccinv, ccsnoopaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               aluout_out, npc_out, instr_out, WBctrl_out, dload_out
    );

endinterface

// File: rtl/link_reg.sv
// LL/SC link register: holds the reserved address, drops it on matching
// snoops or stores, and reports whether an incoming SC may proceed.
module link_reg #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll_set,
    input  logic              st_done,
    input  logic              sc_take,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] sc_addr,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              sc_ok
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              snoop_hit;

    always_comb begin
        snoop_hit = snoop_inv && (snoop_addr == addr_q);
        sc_ok     = valid_q && (addr_q == sc_addr) && !snoop_hit;
        valid_d   = valid_q;
        addr_d    = addr_q;
        if (snoop_hit || sc_take || (st_done && (mem_addr == addr_q))) begin
            valid_d = 1'b0;
        end
        // A completing LL overrides any same-cycle invalidation.
        if (ll_set) begin
            valid_d = 1'b1;
            addr_d  = mem_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline latch and single data-memory access sequencer.
// Define EXMEM_ATOMIC_EN to build the LL/SC link register.
module exmem_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned WB_W   = 4,
    parameter int unsigned MEM_W  = 2,
    parameter int unsigned WORD_W = 32
) (
    input logic    CLK,
    input logic    nRST,
    exmem_if.slave bus
);

    exmem_state_t      state_q, state_d;
    logic [WORD_W-1:0] aluout_q, aluout_d, rdat2_q, rdat2_d, npc_q, npc_d;
    logic [WORD_W-1:0] instr_q, instr_d, dload_q, dload_d;
    logic [WB_W-1:0]   wbctrl_q, wbctrl_d;
    logic [MEM_W-1:0]  memctrl_q, memctrl_d;
    logic              datomic_q, datomic_d;
    logic              stall, load, acc_hit, rd_q, wr_q, rd_in, wr_in;
    logic              sc_in, sc_q, sc_ok;

    assign stall   = (state_q == ACCESS);
    assign load    = bus.ihit && !stall;
    assign acc_hit = stall && bus.dhit;
    // Both request bits set is a write, so a read only counts with write clear.
    assign wr_q    = memctrl_q[MEM_WEN];
    assign rd_q    = memctrl_q[MEM_REN] && !wr_q;
    assign wr_in   = bus.MEMctrl_in[MEM_WEN];
    assign rd_in   = bus.MEMctrl_in[MEM_REN];

`ifdef EXMEM_ATOMIC_EN
    logic ll_q, sc_take;
    assign sc_in   = bus.datomic_in && wr_in;
    assign sc_q    = datomic_q && wr_q;
    assign ll_q    = datomic_q && rd_q;
    assign sc_take = load && !bus.flush_EXMEM && sc_in && sc_ok;

    link_reg #(.WORD_W(WORD_W)) u_link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .ll_set     (acc_hit && ll_q),
        .st_done    (acc_hit && wr_q && !sc_q),
        .sc_take    (sc_take),
        .mem_addr   (aluout_q),
        .sc_addr    (bus.aluout_in),
        .snoop_inv  (bus.ccinv),
        .snoop_addr (bus.ccsnoopaddr),
        .sc_ok      (sc_ok)
    );
`else
    logic unused_atomic;
    assign sc_in         = 1'b0;
    assign sc_q          = 1'b0;
    assign sc_ok         = 1'b0;
    assign unused_atomic = ^{datomic_q, bus.ccinv, bus.ccsnoopaddr};
`endif

    always_comb begin
        state_d   = state_q;
        aluout_d  = aluout_q;
        rdat2_d   = rdat2_q;
        npc_d     = npc_q;
        instr_d   = instr_q;
        dload_d   = dload_q;
        wbctrl_d  = wbctrl_q;
        memctrl_d = memctrl_q;
        datomic_d = datomic_q;
        if (stall) begin
            if (bus.dhit) begin
                state_d = DONE;
                if (rd_q) begin
                    dload_d = bus.dmemload;
                end else if (sc_q) begin
                    dload_d = WORD_W'(1);
                end
            end
        end else if (load) begin
            if (bus.flush_EXMEM) begin
                aluout_d  = '0;
                rdat2_d   = '0;
                npc_d     = '0;
                instr_d   = '0;
                dload_d   = '0;
                wbctrl_d  = '0;
                memctrl_d = '0;
                datomic_d = 1'b0;
                state_d   = IDLE;
            end else begin
                aluout_d  = bus.aluout_in;
                rdat2_d   = bus.rdat2_in;
                npc_d     = bus.npc_in;
                instr_d   = bus.instr_in;
                dload_d   = '0;
                wbctrl_d  = bus.WBctrl_in;
                memctrl_d = bus.MEMctrl_in;
                datomic_d = bus.datomic_in;
                // A failing SC never touches the cache; its result is already 0.
                if (sc_in && !sc_ok) begin
                    state_d = DONE;
                end else if (rd_in || wr_in) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            aluout_q  <= '0;
            rdat2_q   <= '0;
            npc_q     <= '0;
            instr_q   <= '0;
            dload_q   <= '0;
            wbctrl_q  <= '0;
            memctrl_q <= '0;
            datomic_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aluout_q  <= aluout_d;
            rdat2_q   <= rdat2_d;
            npc_q     <= npc_d;
            instr_q   <= instr_d;
            dload_q   <= dload_d;
            wbctrl_q  <= wbctrl_d;
            memctrl_q <= memctrl_d;
            datomic_q <= datomic_d;
        end
    end

    assign bus.mem_stall  = stall;
    assign bus.dmemREN    = stall && rd_q;
    assign bus.dmemWEN    = stall && wr_q;
    assign bus.dmemaddr   = aluout_q;
    assign bus.dmemstore  = rdat2_q;
    assign bus.aluout_out = aluout_q;
    assign bus.npc_out    = npc_q;
    assign bus.instr_out  = instr_q;
    assign bus.WBctrl_out = wbctrl_q;
    assign bus.dload_out  = dload_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed transaction table, reset
// during an access, then random transactions against a transaction-level model.
module tb_exmem_stage;

`ifdef EXMEM_ATOMIC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    typedef enum int {OP_NOP, OP_LW, OP_SW, OP_LL, OP_SC, OP_BOTH, OP_FLUSH} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned lat;
        logic [31:0] ldata;
        logic        snp;
        logic [31:0] snp_addr;
        int unsigned a_stall;
        logic [31:0] a_dload;
        logic        a_wen;
        int unsigned p_stall;
        logic [31:0] p_dload;
        logic        p_wen;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    int          checks = 0;
    int          failures = 0;
    logic        link_v;
    logic [31:0] link_a;
    bit          noise;
    vec_t        tbl [17];
    logic [31:0] pool [4];

    exmem_if #(.WB_W(4), .MEM_W(2), .WORD_W(32)) bus ();

    exmem_stage #(.WB_W(4), .MEM_W(2), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.ihit        = 1'b0;
        bus.flush_EXMEM = 1'b0;
        bus.aluout_in   = '0;
        bus.rdat2_in    = '0;
        bus.npc_in      = '0;
        bus.instr_in    = '0;
        bus.WBctrl_in   = '0;
        bus.MEMctrl_in  = '0;
        bus.datomic_in  = 1'b0;
        bus.dhit        = 1'b0;
        bus.dmemload    = '0;
        bus.ccinv       = 1'b0;
        bus.ccsnoopaddr = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_aluout"}, bus.aluout_out, 32'h0);
        chk({tag, "_npc"}, bus.npc_out, 32'h0);
        chk({tag, "_instr"}, bus.instr_out, 32'h0);
        chk({tag, "_wb"}, 32'(bus.WBctrl_out), 32'h0);
        chk({tag, "_dload"}, bus.dload_out, 32'h0);
        chk({tag, "_stall"}, 32'(bus.mem_stall), 32'h0);
        chk({tag, "_ren"}, 32'(bus.dmemREN), 32'h0);
        chk({tag, "_wen"}, 32'(bus.dmemWEN), 32'h0);
    endtask

    function automatic logic [1:0] mctl(input op_e op);
        case (op)
            OP_LW, OP_LL:           return 2'b01;
            OP_SW, OP_SC, OP_FLUSH: return 2'b10;
            OP_BOTH:                return 2'b11;
            default:                return 2'b00;
        endcase
    endfunction

    function automatic logic snoop_hits(input logic inv, input logic [31:0] a);
        return ATOMIC && inv && link_v && (a == link_a);
    endfunction

    // One instruction through EX/MEM, starting and ending at a falling edge.
    task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned lat, input logic [31:0] ldata, input logic snp,
                         input logic [31:0] snp_addr, output int unsigned stall_n,
                         output logic [31:0] dload_seen, output logic wen_seen);
        logic        is_rd, is_wr, at_sc, at_ll, sc_ok, flush, hit;
        int unsigned exp_stall;
        logic [31:0] exp_dload, e_alu, e_npc, e_instr;
        logic        exp_wen;
        logic [3:0]  e_wb;
        flush = (op == OP_FLUSH);
        is_rd = (op == OP_LW) || (op == OP_LL);
        is_wr = (op == OP_SW) || (op == OP_SC) || (op == OP_BOTH);
        at_sc = ATOMIC && (op == OP_SC);
        at_ll = ATOMIC && (op == OP_LL);
        hit   = snoop_hits(snp, snp_addr);
        sc_ok = link_v && (link_a == addr) && !hit;
        exp_stall = ((is_rd || is_wr) && !(at_sc && !sc_ok)) ? lat : 0;
        exp_dload = (is_rd && exp_stall != 0) ? ldata : ((at_sc && sc_ok) ? 32'd1 : 32'd0);
        exp_wen   = is_wr && (exp_stall != 0);
        if (hit || (at_sc && sc_ok)) link_v = 1'b0;

        bus.ihit        = 1'b1;
        bus.flush_EXMEM = flush;
        bus.aluout_in   = addr;
        bus.rdat2_in    = wdata;
        bus.npc_in      = $urandom;
        bus.instr_in    = $urandom;
        bus.WBctrl_in   = 4'($urandom);
        bus.MEMctrl_in  = mctl(op);
        bus.datomic_in  = (op == OP_LL) || (op == OP_SC);
        bus.ccinv       = snp;
        bus.ccsnoopaddr = snp_addr;
        bus.dhit        = noise ? 1'($urandom) : 1'b0;
        bus.dmemload    = $urandom;
        e_alu   = flush ? 32'h0 : addr;
        e_npc   = flush ? 32'h0 : bus.npc_in;
        e_instr = flush ? 32'h0 : bus.instr_in;
        e_wb    = flush ? 4'h0 : bus.WBctrl_in;
        @(negedge CLK);
        chk("aluout_out", bus.aluout_out, e_alu);
        chk("npc_out", bus.npc_out, e_npc);
        chk("instr_out", bus.instr_out, e_instr);
        chk("WBctrl_out", 32'(bus.WBctrl_out), 32'(e_wb));
        chk("dload_clear", bus.dload_out, 32'h0);

        stall_n  = 0;
        wen_seen = 1'b0;
        for (int c = 0; c < int'(lat) + 3; c++) begin
            if (!bus.mem_stall) break;
            stall_n++;
            chk("dmemREN", 32'(bus.dmemREN), 32'(is_rd));
            chk("dmemWEN", 32'(bus.dmemWEN), 32'(is_wr));
            chk("dmemaddr", bus.dmemaddr, addr);
            if (is_wr) chk("dmemstore", bus.dmemstore, wdata);
            wen_seen = wen_seen | bus.dmemWEN;
            // Upstream keeps changing while stalled; the latch must not follow.
            bus.ihit        = 1'($urandom);
            bus.flush_EXMEM = 1'($urandom);
            bus.aluout_in   = $urandom;
            bus.rdat2_in    = $urandom;
            bus.npc_in      = $urandom;
            bus.MEMctrl_in  = 2'($urandom);
            bus.datomic_in  = 1'($urandom);
            bus.ccinv       = noise && 1'($urandom);
            bus.ccsnoopaddr = ($urandom_range(0, 1) == 0) ? link_a : 32'($urandom);
            bus.dhit        = (stall_n == lat);
            bus.dmemload    = (stall_n == lat) ? ldata : 32'($urandom);
            if (snoop_hits(bus.ccinv, bus.ccsnoopaddr)) link_v = 1'b0;
            if (stall_n == lat) begin
                if (ATOMIC && is_wr && !at_sc && addr == link_a) link_v = 1'b0;
                if (at_ll) begin
                    link_v = 1'b1;
                    link_a = addr;
                end
            end
            @(negedge CLK);
            chk("hold_aluout", bus.aluout_out, e_alu);
        end
        drive_idle();
        chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
        chk("dload_out", bus.dload_out, exp_dload);
        chk("wen_seen", 32'(wen_seen), 32'(exp_wen));
        dload_seen = bus.dload_out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        logic [31:0] d;
        logic        w;
        op_e         op;

        tbl[0]  = '{OP_LW,    32'h100, 32'h0,  3, 32'hDEADBEEF, 1'b0, 32'h0,   3, 32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{OP_FLUSH, 32'h180, 32'hAA, 1, 32'h0,        1'b0, 32'h0,   0, 32'h0,        1'b0, 0, 32'h0,        1'b0};
        tbl[2]  = '{OP_LL,    32'h200, 32'h0,  2, 32'h77,       1'b0, 32'h0,   2, 32'h77,       1'b0, 2, 32'h77,       1'b0};
        tbl[3]  = '{OP_SC,    32'h200, 32'h5,  1, 32'h0,        1'b0, 32'h0,   1, 32'h1,        1'b1, 1, 32'h0,        1'b1};
        tbl[4]  = '{OP_SC,    32'h200, 32'h6,  1, 32'h0,        1'b0, 32'h0,   0, 32'h0,        1'b0, 1, 32'h0,        1'b1};
        tbl[5]  = '{OP_LL,    32'h200, 32'h0,  1, 32'h11,       1'b0, 32'h0,   1, 32'h11,       1'b0, 1, 32'h11,       1'b0};
        tbl[6]  = '{OP_NOP,   32'h0,   32'h0,  1, 32'h0,        1'b1, 32'h200, 0, 32'h0,        1'b0, 0, 32'h0,        1'b0};
        tbl[7]  = '{OP_SC,    32'h200, 32'h7,  2, 32'h0,        1'b0, 32'h0,   0, 32'h0,        1'b0, 2, 32'h0,        1'b1};
        tbl[8]  = '{OP_LL,    32'h300, 32'h0,  1, 32'h33,       1'b0, 32'h0,   1, 32'h33,       1'b0, 1, 32'h33,       1'b0};
        tbl[9]  = '{OP_SC,    32'h300, 32'h8,  1, 32'h0,        1'b1, 32'h300, 0, 32'h0,        1'b0, 1, 32'h0,        1'b1};
        tbl[10] = '{OP_BOTH,  32'h400, 32'h9,  2, 32'h44,       1'b0, 32'h0,   2, 32'h0,        1'b1, 2, 32'h0,        1'b1};
        tbl[11] = '{OP_NOP,   32'h500, 32'h0,  1, 32'h0,        1'b0, 32'h0,   0, 32'h0,        1'b0, 0, 32'h0,        1'b0};
        tbl[12] = '{OP_LL,    32'h600, 32'h0,  1, 32'h66,       1'b0, 32'h0,   1, 32'h66,       1'b0, 1, 32'h66,       1'b0};
        tbl[13] = '{OP_SW,    32'h600, 32'h1,  1, 32'h0,        1'b0, 32'h0,   1, 32'h0,        1'b1, 1, 32'h0,        1'b1};
        tbl[14] = '{OP_SC,    32'h600, 32'h2,  1, 32'h0,        1'b0, 32'h0,   0, 32'h0,        1'b0, 1, 32'h0,        1'b1};
        tbl[15] = '{OP_LL,    32'h700, 32'h0,  1, 32'h70,       1'b0, 32'h0,   1, 32'h70,       1'b0, 1, 32'h70,       1'b0};
        tbl[16] = '{OP_SC,    32'h700, 32'h3,  4, 32'h0,        1'b0, 32'h0,   4, 32'h1,        1'b1, 4, 32'h0,        1'b1};
        pool[0] = 32'h100;
        pool[1] = 32'h200;
        pool[2] = 32'h300;
        pool[3] = 32'h400;

        drive_idle();
        nRST   = 1'b0;
        link_v = 1'b0;
        link_a = 32'h0;
        noise  = 1'b0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        nRST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].ldata,
                  tbl[i].snp, tbl[i].snp_addr, s, d, w);
            chk($sformatf("tbl%0d_stall", i), 32'(s), 32'(ATOMIC ? tbl[i].a_stall : tbl[i].p_stall));
            chk($sformatf("tbl%0d_dload", i), d, ATOMIC ? tbl[i].a_dload : tbl[i].p_dload);
            chk($sformatf("tbl%0d_wen", i), 32'(w), 32'(ATOMIC ? tbl[i].a_wen : tbl[i].p_wen));
        end

        // Reset held for two cycles in the middle of an access.
        bus.ihit       = 1'b1;
        bus.aluout_in  = 32'h800;
        bus.npc_in     = 32'h804;
        bus.instr_in   = 32'h8C000000;
        bus.WBctrl_in  = 4'hF;
        bus.MEMctrl_in = 2'b01;
        @(negedge CLK);
        chk("rstacc_stall", 32'(bus.mem_stall), 32'h1);
        drive_idle();
        @(negedge CLK);
        nRST         = 1'b0;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hBADBAD00;
        repeat (2) @(negedge CLK);
        chk_zero("rstacc");
        nRST     = 1'b1;
        bus.dhit = 1'b0;
        link_v   = 1'b0;
        @(negedge CLK);
        chk("rstacc_after_stall", 32'(bus.mem_stall), 32'h0);
        chk("rstacc_after_ren", 32'(bus.dmemREN), 32'h0);
        chk("rstacc_after_dload", bus.dload_out, 32'h0);

        noise = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = op_e'($urandom_range(0, 6));
            issue(op, pool[$urandom_range(0, 3)], $urandom, $urandom_range(1, 4), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0) ? link_a : pool[$urandom_range(0, 3)],
                  s, d, w);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
